// File: rtl/alu_result_checker.sv
// alu_result_checker: pipelined golden-model checker for ALU result vectors.
// Define ALU_CHK_STOP_ON_FAIL_EN to halt intake on the first failing vector.
module alu_result_checker #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] mux_result1,
  input  logic [WIDTH-1:0] mux_result2,
  input  logic [WIDTH-1:0] xor_result,
  input  logic [WIDTH-1:0] and_result,
  input  logic [WIDTH-1:0] or_result,
  input  logic [WIDTH-1:0] add_result,
  input  logic [WIDTH-1:0] mux_peres_result,
  input  logic [WIDTH-1:0] nand_result,
  input  logic [WIDTH-1:0] nor_result,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [8:0]       fail_mask,
  output logic [8:0]       first_fail_mask,
  output logic             err_pulse,
  output logic             halted
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state_q, state_d;
  logic v1_q, v2_q, err_q, flush, acc, fail1, fail2;
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic [WIDTH-1:0] r_q [9];
  logic [WIDTH-1:0] g [9];
  logic [8:0] mm, mm2_q, fmask_q, ffm_q;
  logic [CNT_W-1:0] pass_q, fail_q;
  assign flush = rst | clear;
  assign acc   = in_valid & in_ready;
  assign g[0] = (~c_q & a_q) | (c_q & b_q);
  assign g[1] = (~c_q & b_q) | (c_q & a_q);
  assign g[2] = a_q ^ b_q;
  assign g[3] = a_q & b_q;
  assign g[4] = a_q | b_q;
  assign g[5] = a_q + b_q;
  assign g[6] = (a_q & b_q) ^ c_q;
  assign g[7] = ~(a_q & b_q);
  assign g[8] = ~(a_q | b_q);
  for (genvar i = 0; i < 9; i++) begin : g_cmp
    assign mm[i] = g[i] != r_q[i];
  end
  assign fail1 = v1_q & |mm;
  assign fail2 = v2_q & |mm2_q;
  // Halting one stage early lets the vector right behind the failing one drain and be scored.
  always_comb begin
    state_d = state_q;
    if (acc && state_q == IDLE) state_d = RUN;
`ifdef ALU_CHK_STOP_ON_FAIL_EN
    if (fail1) state_d = HALT;
`endif
    if (flush) state_d = IDLE;
  end
`ifdef ALU_CHK_STOP_ON_FAIL_EN
  assign halted = state_q == HALT;
`else
  assign halted = 1'b0;
`endif
  assign in_ready        = ~halted;
  assign pass_count      = pass_q;
  assign fail_count      = fail_q;
  assign fail_mask       = fmask_q;
  assign first_fail_mask = ffm_q;
  assign err_pulse       = err_q;
  always_ff @(posedge clk) begin
    state_q <= state_d;
    if (acc) begin
      a_q <= A;
      b_q <= B;
      c_q <= C;
      r_q <= '{mux_result1, mux_result2, xor_result, and_result, or_result,
               add_result, mux_peres_result, nand_result, nor_result};
    end
    if (flush) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      err_q   <= 1'b0;
      mm2_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      fmask_q <= '0;
      ffm_q   <= '0;
    end else begin
      v1_q  <= acc;
      v2_q  <= v1_q;
      mm2_q <= mm;
      err_q <= fail2;
      if (v2_q && !fail2 && ~&pass_q) pass_q <= pass_q + CNT_W'(1);
      if (fail2) begin
        fmask_q <= fmask_q | mm2_q;
        if (fail_q == '0) ffm_q <= mm2_q;
        if (~&fail_q) fail_q <= fail_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker: directed vectors against a queue-based scoring model, plus literal pins.
module tb_alu_result_checker;
  typedef logic [8:0][31:0] res_t;
  typedef struct {int t; logic [8:0] m;} ent_t;
  logic clk = 0, rst = 1, clear = 0, in_valid = 0;
  logic [31:0] A = 0, B = 0, C = 0;
  logic [31:0] r [9] = '{default: 32'h0};
  logic        in_ready, err_pulse, halted, rdy4, err4, h4;
  logic [15:0] pass_count, fail_count;
  logic [3:0]  p4, f4;
  logic [8:0]  fail_mask, first_fail_mask, fm4, ffm4;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, m_pass = 0, m_fail = 0, m_p4 = 0, m_f4 = 0;
  logic [8:0] m_fm = 0, m_ffm = 0;
  bit m_err = 0, m_halt = 0, rdy;
  ent_t pend[$];
  ent_t e;
  res_t gp;

  always #5 clk = ~clk;

  alu_result_checker dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .C(C), .mux_result1(r[0]), .mux_result2(r[1]), .xor_result(r[2]),
    .and_result(r[3]), .or_result(r[4]), .add_result(r[5]), .mux_peres_result(r[6]),
    .nand_result(r[7]), .nor_result(r[8]), .pass_count(pass_count), .fail_count(fail_count),
    .fail_mask(fail_mask), .first_fail_mask(first_fail_mask), .err_pulse(err_pulse), .halted(halted));

  alu_result_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy4),
    .A(A), .B(B), .C(C), .mux_result1(r[0]), .mux_result2(r[1]), .xor_result(r[2]),
    .and_result(r[3]), .or_result(r[4]), .add_result(r[5]), .mux_peres_result(r[6]),
    .nand_result(r[7]), .nor_result(r[8]), .pass_count(p4), .fail_count(f4),
    .fail_mask(fm4), .first_fail_mask(ffm4), .err_pulse(err4), .halted(h4));

  function automatic res_t gold(input logic [31:0] a, b, c);
    res_t g;
    g[0] = (~c & a) | (c & b);
    g[1] = (~c & b) | (c & a);
    g[2] = a ^ b;
    g[3] = a & b;
    g[4] = a | b;
    g[5] = a + b;
    g[6] = (a & b) ^ c;
    g[7] = ~(a & b);
    g[8] = ~(a | b);
    return g;
  endfunction

  function automatic logic [8:0] mask_of();
    res_t g = gold(A, B, C);
    logic [8:0] m;
    for (int i = 0; i < 9; i++) m[i] = r[i] !== g[i];
    return m;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  // Scoring model: each accepted vector is scored exactly two edges after acceptance.
  always @(posedge clk) begin
    rdy = !m_halt;
    if (rst || clear) begin
      pend.delete();
      m_pass = 0; m_fail = 0; m_p4 = 0; m_f4 = 0;
      m_fm = 0; m_ffm = 0; m_err = 0; m_halt = 0;
    end else begin
      m_err = 0;
      if (pend.size() > 0 && pend[0].t == cyc - 2) begin
        e = pend.pop_front();
        if (e.m == 0) begin
          if (m_pass < 65535) m_pass++;
          if (m_p4 < 15) m_p4++;
        end else begin
          if (m_fail == 0) m_ffm = e.m;
          if (m_fail < 65535) m_fail++;
          if (m_f4 < 15) m_f4++;
          m_fm |= e.m;
          m_err = 1;
        end
      end
`ifdef ALU_CHK_STOP_ON_FAIL_EN
      if (pend.size() > 0 && pend[0].m != 0) m_halt = 1;
`endif
      if (in_valid && rdy) pend.push_back('{t: cyc, m: mask_of()});
    end
    cyc++;
  end

  always @(negedge clk) begin
    chk("pass_count", pass_count, m_pass);
    chk("fail_count", fail_count, m_fail);
    chk("fail_mask", fail_mask, m_fm);
    chk("first_fail_mask", first_fail_mask, m_ffm);
    chk("err_pulse", err_pulse, m_err);
    chk("halted", halted, m_halt);
    chk("in_ready", in_ready, !m_halt);
    chk("pass4", p4, m_p4);
    chk("fail4", f4, m_f4);
    chk("err4", err4, m_err);
    chk("fmask4", fm4, m_fm);
    chk("ffm4", ffm4, m_ffm);
    chk("ready4", rdy4, !m_halt);
    chk("halted4", h4, m_halt);
  end

  task automatic put(input logic [31:0] a, b, c, input int bad, input logic [31:0] flip);
    res_t g = gold(a, b, c);
    A = a; B = b; C = c; in_valid = 1;
    for (int i = 0; i < 9; i++) r[i] = g[i] ^ ((i == bad) ? flip : 32'h0);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    in_valid = 0; clear = 1;
    @(negedge clk);
    clear = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_pass", pass_count, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_err", err_pulse, 0);
    chk("rst_halted", halted, 0);
    rst = 0;
    gp = gold(32'hFFFFFFFF, 32'h0, 32'h1);
    chk("gold_mux1", gp[0], 32'hFFFFFFFE);
    chk("gold_mux2", gp[1], 32'h00000001);
    chk("gold_add", gp[5], 32'hFFFFFFFF);
    chk("gold_peres", gp[6], 32'h00000001);
    chk("gold_nor", gp[8], 32'h0);
    put(0, 0, 0, -1, 0);
    idle(1);
    chk("lat_n1_pass", pass_count, 0);
    idle(1);
    chk("lat_n2_pass", pass_count, 1);
    chk("lat_n2_fmask", fail_mask, 0);
    put(32'hFFFFFFFF, 0, 1, -1, 0);
    idle(2);
    chk("ones_pass", pass_count, 2);
    put(32'hFFFFFFFF, 0, 1, 5, 32'hFFFFFFFF);
    idle(2);
    chk("add_fail", fail_count, 1);
    chk("add_fmask", fail_mask, 9'h020);
    chk("add_ffm", first_fail_mask, 9'h020);
    chk("add_err", err_pulse, 1);
    idle(1);
    chk("add_err_off", err_pulse, 0);
    do_clear();
    chk("clr_pass", pass_count, 0);
    chk("clr_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) put(32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, (k == 1) ? 8 : -1, 1);
    idle(3);
`ifdef ALU_CHK_STOP_ON_FAIL_EN
    chk("b2b_pass", pass_count, 2);
    chk("b2b_halted", halted, 1);
    chk("b2b_ready", in_ready, 0);
`else
    chk("b2b_pass", pass_count, 3);
    chk("b2b_fmask", fail_mask, 9'h100);
`endif
    chk("b2b_fail", fail_count, 1);
    do_clear();
    put(1, 2, 3, 0, 1);
    clear = 1;
    put(4, 5, 6, -1, 0);
    clear = 0;
    idle(3);
    chk("clracc_pass", pass_count, 0);
    chk("clracc_fail", fail_count, 0);
    put(7, 8, 9, 3, 32'h10);
    in_valid = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    idle(3);
    chk("rst_mid_fail", fail_count, 0);
    chk("rst_mid_err", err_pulse, 0);
    for (int k = 0; k < 17; k++) put(32'(k * 32'h01010101), 32'(~k), (k % 2 == 1) ? 32'hFFFFFFFF : 32'h0, -1, 0);
    idle(3);
    chk("sat_p4", p4, 15);
    chk("sat_p16", pass_count, 17);
    put(1, 1, 1, 2, 1);
    idle(2);
    chk("sat_f4", f4, 1);
    chk("sat_err4", err4, 1);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
